// File: rtl/adc_emulator.sv
// adc_emulator: LTC2315-style serial ADC responder with pattern generator and start-bit error injection
module adc_emulator #(
  parameter int DATA_W      = 12,
  parameter int ABORT_CNT_W = 8
) (
  input  logic                   sck,
  input  logic                   rst,
  input  logic                   cs_n,
  output logic                   miso,
  output logic                   miso_oe,
  input  logic [1:0]             mode_i,
  input  logic [DATA_W-1:0]      sample_i,
  input  logic                   inject_err_i,
  output logic                   frame_o,
  output logic [DATA_W-1:0]      sample_o,
  output logic                   abort_o,
  output logic [ABORT_CNT_W-1:0] abort_count_o
);
  localparam logic [3:0] LAST = 4'(DATA_W);
  localparam logic [DATA_W-1:0] ALT_INIT = {(DATA_W/2){2'b10}};
  localparam logic [DATA_W-1:0] MID_SCALE = {1'b1, {(DATA_W-1){1'b0}}};
  logic [3:0] bit_cnt, idx;
  logic [DATA_W-1:0] shreg, ramp, alt, src;
  assign miso_oe = ~cs_n;
  always_comb begin
    src = mode_i == 2'd0 ? sample_i : mode_i == 2'd1 ? ramp : mode_i == 2'd2 ? alt : MID_SCALE;
    idx = LAST - 4'd1 - bit_cnt;
  end
  // bit_cnt: 0 idle/awaiting first bit, 1..LAST shifting, LAST+1 trailing zeros
  always_ff @(posedge sck) begin
    if (rst) begin
      miso          <= 1'b0;
      bit_cnt       <= '0;
      shreg         <= '0;
      frame_o       <= 1'b0;
      abort_o       <= 1'b0;
      sample_o      <= '0;
      abort_count_o <= '0;
      ramp          <= '0;
      alt           <= ALT_INIT;
    end else begin
      frame_o <= 1'b0;
      abort_o <= 1'b0;
      if (cs_n) begin
        bit_cnt <= '0;
        miso    <= inject_err_i;
        if (bit_cnt != 4'd0 && bit_cnt <= LAST) begin
          abort_o <= 1'b1;
          if (~&abort_count_o) abort_count_o <= abort_count_o + 1'b1;
        end
      end else if (bit_cnt == 4'd0) begin
        shreg   <= src;
        miso    <= src[DATA_W-1];
        bit_cnt <= 4'd1;
      end else if (bit_cnt < LAST) begin
        miso    <= shreg[idx];
        bit_cnt <= bit_cnt + 4'd1;
      end else if (bit_cnt == LAST) begin
        miso     <= 1'b0;
        bit_cnt  <= LAST + 4'd1;
        frame_o  <= 1'b1;
        sample_o <= shreg;
        ramp     <= ramp + 1'b1;
        alt      <= ~alt;
      end else begin
        miso <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_adc_emulator.sv
// tb_adc_emulator: scoreboard bench driving nominal, aborted, injected and reset-interrupted frames
module tb_adc_emulator;
  logic sck = 1'b0, rst = 1'b1, cs_n = 1'b1, inject_err_i = 1'b0;
  logic [1:0] mode_i = 2'd0;
  logic [11:0] sample_i = '0;
  logic miso, miso_oe, frame_o, abort_o;
  logic [11:0] sample_o;
  logic [7:0] abort_count_o;
  int passed = 0, total = 0, cyc = 0, prev_cyc = 0, frames_seen = 0, aborts_seen = 0;
  bit spacing_en = 0, prev_valid = 0;
  logic [11:0] expq[$];
  logic [11:0] ramp_m = '0, alt_m = 12'hAAA;

  adc_emulator dut (
    .sck(sck), .rst(rst), .cs_n(cs_n), .miso(miso), .miso_oe(miso_oe),
    .mode_i(mode_i), .sample_i(sample_i), .inject_err_i(inject_err_i),
    .frame_o(frame_o), .sample_o(sample_o), .abort_o(abort_o), .abort_count_o(abort_count_o)
  );

  always #5 sck = ~sck;
  always @(posedge sck) cyc++;

  always @(negedge sck) begin
    logic [11:0] e;
    if (abort_o) aborts_seen++;
    if (frame_o) begin
      frames_seen++;
      total++;
      if (expq.size() == 0) $display("FAIL frame_unexpected: sample_o=%h, no frame expected", sample_o);
      else begin
        e = expq.pop_front();
        if (sample_o !== e) $display("FAIL frame_sample: got %h want %h", sample_o, e);
        else passed++;
      end
      if (spacing_en) begin
        if (prev_valid) begin
          total++;
          if (cyc - prev_cyc != 18) $display("FAIL frame_spacing: got %0d want 18", cyc - prev_cyc);
          else passed++;
        end
        prev_valid = 1;
        prev_cyc = cyc;
      end
    end
  end

  task automatic do_reset();
    @(posedge sck); #1 rst = 1; cs_n = 1; inject_err_i = 0;
    repeat (2) @(posedge sck);
    #1 rst = 0;
    ramp_m = '0;
    alt_m = 12'hAAA;
    expq.delete();
  endtask

  task automatic frame(input logic [1:0] m, input logic [11:0] s, input bit inj, input bit chk,
                       input bit mid, input logic [1:0] mid_m);
    logic [11:0] e;
    logic b;
    mode_i = m; sample_i = s; inject_err_i = inj;
    e = m == 2'd0 ? s : m == 2'd1 ? ramp_m : m == 2'd2 ? alt_m : 12'h800;
    expq.push_back(e);
    @(posedge sck); #1 cs_n = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge sck);
      if (chk) begin
        b = k == 0 ? inj : k <= 12 ? e[12-k] : 1'b0;
        total++;
        if (miso !== b) $display("FAIL miso_bit N%0d: got %b want %b", k, miso, b);
        else passed++;
        if (k == 0) begin
          total++;
          if (miso_oe !== 1'b1) $display("FAIL miso_oe: got %b want 1", miso_oe);
          else passed++;
        end
      end
      if (mid && k == 4) begin
        @(posedge sck); #1 mode_i = mid_m; sample_i = ~s;
      end
    end
    @(posedge sck); #1 cs_n = 1; inject_err_i = 0;
    ramp_m = ramp_m + 12'd1;
    alt_m = ~alt_m;
    repeat (3) @(posedge sck);
    #1;
  endtask

  task automatic abort_once(output logic ab, output logic [7:0] cnt);
    mode_i = 2'd1;
    @(posedge sck); #1 cs_n = 0;
    repeat (6) @(posedge sck);
    #1 cs_n = 1;
    @(posedge sck);
    @(negedge sck);
    ab = abort_o;
    cnt = abort_count_o;
    repeat (2) @(posedge sck);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge sck);
    @(negedge sck);
    total += 6;
    if (miso !== 1'b0) $display("FAIL reset_miso: got %b want 0", miso); else passed++;
    if (frame_o !== 1'b0) $display("FAIL reset_frame: got %b want 0", frame_o); else passed++;
    if (abort_o !== 1'b0) $display("FAIL reset_abort: got %b want 0", abort_o); else passed++;
    if (sample_o !== 12'h000) $display("FAIL reset_sample: got %h want 000", sample_o); else passed++;
    if (abort_count_o !== 8'd0) $display("FAIL reset_abort_count: got %0d want 0", abort_count_o); else passed++;
    if (miso_oe !== 1'b0) $display("FAIL reset_miso_oe: got %b want 0", miso_oe); else passed++;
    @(posedge sck); #1 rst = 0;
  endtask

  task automatic test_basic();
    int f0 = frames_seen;
    frame(2'd0, 12'hABC, 1'b0, 1'b1, 1'b0, 2'd0);
    total += 2;
    if (frames_seen - f0 !== 1) $display("FAIL basic_frame_count: got %0d want 1", frames_seen - f0); else passed++;
    if (aborts_seen !== 0) $display("FAIL basic_abort: got %0d want 0", aborts_seen); else passed++;
  endtask

  task automatic test_ramp();
    do_reset();
    prev_valid = 0;
    spacing_en = 1;
    for (int i = 0; i < 4098; i++) frame(2'd1, 12'h000, 1'b0, i < 3 || i > 4094, 1'b0, 2'd0);
    spacing_en = 0;
  endtask

  task automatic test_mode();
    do_reset();
    frame(2'd2, 12'h000, 1'b0, 1'b1, 1'b0, 2'd0);
    frame(2'd2, 12'h000, 1'b0, 1'b0, 1'b0, 2'd0);
    frame(2'd2, 12'h123, 1'b0, 1'b1, 1'b1, 2'd3);
    frame(2'd3, 12'h000, 1'b0, 1'b1, 1'b0, 2'd0);
    frame(2'd0, 12'h3C5, 1'b0, 1'b0, 1'b1, 2'd1);
  endtask

  task automatic test_abort();
    logic ab;
    logic [7:0] cnt;
    int f0, a0;
    do_reset();
    f0 = frames_seen;
    a0 = aborts_seen;
    abort_once(ab, cnt);
    total += 4;
    if (ab !== 1'b1) $display("FAIL abort_pulse: got %b want 1", ab); else passed++;
    if (cnt !== 8'd1) $display("FAIL abort_count_first: got %0d want 1", cnt); else passed++;
    if (frames_seen !== f0) $display("FAIL abort_no_frame: got %0d want %0d", frames_seen, f0); else passed++;
    if (aborts_seen - a0 !== 1) $display("FAIL abort_single: got %0d want 1", aborts_seen - a0); else passed++;
    frame(2'd1, 12'h000, 1'b0, 1'b1, 1'b0, 2'd0);
    for (int i = 2; i <= 300; i++) begin
      abort_once(ab, cnt);
      total++;
      if (ab !== 1'b1 || cnt !== 8'(i > 255 ? 255 : i))
        $display("FAIL abort_sat #%0d: got pulse=%b count=%0d want pulse=1 count=%0d", i, ab, cnt, i > 255 ? 255 : i);
      else passed++;
    end
  endtask

  task automatic test_inject();
    int f0 = frames_seen;
    frame(2'd0, 12'h5A3, 1'b1, 1'b1, 1'b0, 2'd0);
    frame(2'd0, 12'hFFF, 1'b0, 1'b1, 1'b0, 2'd0);
    total++;
    if (frames_seen - f0 !== 2) $display("FAIL inject_frames: got %0d want 2", frames_seen - f0); else passed++;
  endtask

  task automatic test_rst_mid();
    int f0 = frames_seen, a0 = aborts_seen;
    mode_i = 2'd1;
    @(posedge sck); #1 cs_n = 0;
    repeat (6) @(posedge sck);
    #1 rst = 1;
    @(posedge sck);
    @(negedge sck);
    total += 2;
    if (miso !== 1'b0) $display("FAIL rst_mid_miso: got %b want 0", miso); else passed++;
    if (abort_count_o !== 8'd0) $display("FAIL rst_mid_abort_count: got %0d want 0", abort_count_o); else passed++;
    @(posedge sck); #1 rst = 0; cs_n = 1;
    @(negedge sck);
    total++;
    if (miso !== 1'b0) $display("FAIL rst_mid_miso_after: got %b want 0", miso); else passed++;
    repeat (2) @(posedge sck);
    #1;
    total += 2;
    if (frames_seen !== f0) $display("FAIL rst_mid_frame: got %0d want %0d", frames_seen, f0); else passed++;
    if (aborts_seen !== a0) $display("FAIL rst_mid_abort: got %0d want %0d", aborts_seen, a0); else passed++;
    ramp_m = '0;
    alt_m = 12'hAAA;
    frame(2'd1, 12'h000, 1'b0, 1'b1, 1'b0, 2'd0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ramp();
    test_mode();
    test_abort();
    test_inject();
    test_rst_mid();
    repeat (2) @(posedge sck);
    total++;
    if (expq.size() != 0) $display("FAIL scoreboard_drain: got %0d pending want 0", expq.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/adc_emulator.md
# adc_emulator

Synthesisable model of the LTC2315 serial ADC. It is the responder end of the ADC serial link: it receives `cs_n` and `sck` from the ADC master and drives `miso` with one leading zero, 12 data bits MSB first, then trailing zeros. It is used for on-board loopback and bench bring-up of the receive chain without the physical ADC. Sample data comes from an external port or an internal pattern generator, and the block can inject a start-bit error.

## Interface
Parameters
- `DATA_W`, 12: sample width; the frame timing below assumes 12.
- `ABORT_CNT_W`, 8: width of the aborted-frame counter.

Ports
- `sck` in 1: serial clock; the only clock. All logic is on `posedge sck`.
- `rst` in 1: reset, synchronous, active-high.
- `cs_n` in 1: chip select from the master, active low; driven by the master on `posedge sck`.
- `miso` out 1: serial data to the master, registered; the master samples it on `negedge sck`.
- `miso_oe` out 1: pad output enable, combinational `~cs_n`.
- `mode_i` in 2: sample source. 0 = `sample_i`, 1 = ramp, 2 = alternating 0xAAA/0x555, 3 = constant 0x800.
- `sample_i` in DATA_W: external sample, used when `mode_i` = 0.
- `inject_err_i` in 1: drive the leading bit as 1 instead of 0.
- `frame_o` out 1: one-cycle pulse when a full 12-bit frame has been shifted out.
- `sample_o` out DATA_W: value sent in the last completed frame; valid while `frame_o` is high and held until the next completed frame.
- `abort_o` out 1: one-cycle pulse when `cs_n` rises mid-frame.
- `abort_count_o` out ABORT_CNT_W: number of aborted frames; saturates at all-ones.

## Operation
- State is `bit_cnt[3:0]`, 0..13. The value 0 means idle or waiting for the first data bit.
- Idle (`cs_n` = 1 at the edge):
  - `bit_cnt` <= 0.
  - `miso` <= `inject_err_i`, the leading-bit value. Normally 0.
  - If `bit_cnt` was 1..12, pulse `abort_o` and increment `abort_count_o` (saturating). `frame_o` does not pulse and the pattern generator does not advance.
- First edge with `cs_n` = 0 and `bit_cnt` = 0:
  - Latch the selected source into `shreg`.
  - `miso` <= source[11].
  - `bit_cnt` <= 1.
- `cs_n` = 0 and `bit_cnt` = 1..11: `miso` <= `shreg[11 - bit_cnt]`, `bit_cnt`++.
- `cs_n` = 0 and `bit_cnt` = 12:
  - `miso` <= 0 (trailing zero).
  - `bit_cnt` <= 13.
  - Pulse `frame_o`, `sample_o` <= `shreg`, advance the pattern generator.
- `cs_n` = 0 and `bit_cnt` = 13: `miso` <= 0 and `bit_cnt` holds at 13 (trailing zeros for any length).
- `cs_n` rising while `bit_cnt` = 13 ends the frame normally; no abort.
- Pattern generator:
  - Ramp: 12-bit value, +1 per completed frame, wraps 0xFFF -> 0x000.
  - Alternating: toggles per completed frame, starting at 0xAAA.
  - Both generators run in every mode; `mode_i` only selects which one feeds the frame.
  - `mode_i` and `sample_i` are sampled only at the frame-start edge; changes mid-frame do not affect the frame in progress.
- Reset values:
  - `miso` 0, `bit_cnt` 0, `shreg` 0.
  - `frame_o` 0, `abort_o` 0, `sample_o` 0, `abort_count_o` 0.
  - Ramp 0, alternating 0xAAA.
- Reset mid-frame: the frame is dropped. No `frame_o`, no `abort_o`, and `miso` is 0 from the next edge.

## Timing
- Let P0 be the posedge at which the master drives `cs_n` low.
- The master samples on negedges N0, N1, … following P0, P1, ….
- Bit schedule:
  - N0: `miso` holds the idle value (leading 0, or 1 when injecting).
  - P1: the block first sees `cs_n` = 0 and drives bit 11, sampled at N1.
  - Pk (k = 1..12): drives bit 12−k, sampled at Nk.
  - P13: drives 0, sampled at N13, where the master checks for the trailing zero.
- `frame_o` and `sample_o` update at P13 and are visible in the cycle after P13.
- `abort_o` is high in the cycle after the first edge at which `cs_n` = 1 is seen with `bit_cnt` in 1..12.
- Nominal master frame: 18 sck cycles with `cs_n` low for 14 of them.
  - Steady state is one `frame_o` per 18 cycles.
  - There is no minimum `cs_n`-high time beyond 1 cycle.
- `miso_oe` has zero latency from `cs_n`.

## Test plan
- `mode_i`=0, `sample_i`=0xABC, one nominal frame:
  - Expect `miso` at N0..N13 = 0,1,0,1,0,1,0,1,1,1,1,0,0,0.
  - Expect one `frame_o` pulse with `sample_o`=0xABC.
  - Expect `abort_o` never set.
- `mode_i`=1, 4098 back-to-back 18-cycle frames:
  - Expect `sample_o` = 0x000, 0x001, …, 0xFFF, 0x000, 0x001.
  - Expect frames exactly 18 cycles apart.
- `mode_i`=2 for three frames, then `mode_i`=3:
  - Expect `sample_o` = 0xAAA, 0x555, 0xAAA, then 0x800.
  - Changing `mode_i` at P5 of a frame leaves that frame's value unchanged.
- `cs_n` raised after P6:
  - Expect `abort_o` pulse, `abort_count_o`=1, no `frame_o`, and the ramp not advanced.
  - 300 aborts leave `abort_count_o` = 255.
- `inject_err_i`=1 held for one frame:
  - Expect `miso`=1 at N0.
  - Data bits unchanged, trailing bit 0.
  - `frame_o` still pulses.
- `rst` asserted at P7 and released two cycles later with `cs_n` still low:
  - Expect `miso`=0, no `frame_o`, `abort_count_o`=0.
  - The next `cs_n`-low edge starts a clean frame, with ramp sample 0x000.
